// File: rtl/slave_mem_responder.sv
// ---------------------------------------------------------------------------
// slave_mem_responder
//
// Slave-side responder for the request/ack bus. It takes one transaction at
// a time, acknowledges it after a number of wait states, and then either
// commits the write into a small register-file memory or presents the read
// data for exactly one cycle after the ack.
//
// Parameters
//   DEPTH_LOG2   memory holds 2**DEPTH_LOG2 32-bit words
//   WAIT_CYCLES  wait states between request capture and ack (0..15)
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset
//   req          request from the interconnect, held high until ack
//   cmd          0 = read, 1 = write (valid while req is high)
//   addr         byte address; word index is addr[DEPTH_LOG2+1:2]
//   wdata        write data (valid while req and cmd are high)
//   ack          one-cycle acknowledge
//   rdata        read data, nonzero only in the cycle after a read ack
//   rdata_valid  high for exactly the cycle rdata is driven
//   busy         high whenever a transaction is in flight
//
// Optional feature
//   SLAVE_RAND_WAIT_EN  when defined, WAIT_CYCLES is ignored and each
//                       transaction's wait count comes from a 4-bit LFSR
//                       (x^4 + x^3 + 1, seed 4'b1001), giving 0..3 waits.
// ---------------------------------------------------------------------------
module slave_mem_responder #(
  parameter int DEPTH_LOG2  = 4,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        cmd,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        busy
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2,
    DATA = 2'd3
  } state_t;

  state_t                  state;
  state_t                  next_state;
  logic                    capture;
  logic [3:0]              wait_cnt;
  logic [3:0]              init_wait;
  logic [DEPTH_LOG2-1:0]   cap_idx;
  logic                    cap_cmd;
  logic [31:0]             cap_wdata;
  logic [31:0]             mem [DEPTH];
  logic                    mem_we;

  // Address bits outside the word index are deliberately ignored, which
  // makes upper addresses alias onto the memory.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr[31:DEPTH_LOG2+2], addr[1:0]};

`ifdef SLAVE_RAND_WAIT_EN
  // Pseudo-random wait source. The current value sets the wait count of the
  // request being captured, and the register steps once per capture so the
  // sequence is reproducible from reset.
  logic [3:0] lfsr;

  assign init_wait = {2'b00, lfsr[1:0]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr <= 4'b1001;
    end else if (capture) begin
      lfsr <= {lfsr[2:0], lfsr[3] ^ lfsr[2]};
    end
  end
`else
  localparam logic [3:0] FIXED_WAIT = 4'(WAIT_CYCLES);

  assign init_wait = FIXED_WAIT;
`endif

  // Next-state logic. Inputs matter only in IDLE (capture) and WAIT (abort
  // when the master drops req); ACK and DATA always run to completion.
  always_comb begin
    next_state = state;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          capture    = 1'b1;
          next_state = (init_wait == 4'd0) ? ACK : WAIT;
        end
      end
      WAIT: begin
        if (!req) begin
          next_state = IDLE;
        end else if (wait_cnt == 4'd1) begin
          next_state = ACK;
        end
      end
      ACK: begin
        next_state = cap_cmd ? IDLE : DATA;
      end
      DATA: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // State register plus the captured request. The wait counter is loaded on
  // capture and counts down while in WAIT; it is cleared whenever WAIT is
  // left, including on an abort.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      wait_cnt  <= 4'd0;
      cap_idx   <= '0;
      cap_cmd   <= 1'b0;
      cap_wdata <= 32'd0;
    end else begin
      state <= next_state;
      if (capture) begin
        cap_idx   <= addr[DEPTH_LOG2+1:2];
        cap_cmd   <= cmd;
        cap_wdata <= wdata;
        wait_cnt  <= init_wait;
      end else if (state == WAIT) begin
        wait_cnt <= (next_state == WAIT) ? (wait_cnt - 4'd1) : 4'd0;
      end
    end
  end

  // The write lands on the edge that ends the ACK cycle, so any read
  // captured afterwards sees it. Reset clears every word.
  assign mem_we = (state == ACK) && cap_cmd;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= 32'd0;
      end
    end else if (mem_we) begin
      mem[cap_idx] <= cap_wdata;
    end
  end

  // Outputs are decoded straight from the state so they drop to zero the
  // moment reset is asserted.
  always_comb begin
    ack         = 1'b0;
    rdata_valid = 1'b0;
    rdata       = 32'd0;
    busy        = (state != IDLE);
    case (state)
      ACK: begin
        ack = 1'b1;
      end
      DATA: begin
        rdata_valid = 1'b1;
        rdata       = mem[cap_idx];
      end
      default: begin
        ack = 1'b0;
      end
    endcase
  end

endmodule
